filter_job_controller: RTL and testbench

Sequences one full-frame filter job for the image-filter coprocessor. The HPS triggers it through the 2-bit ACTIVATE PIO (bit0 = start, bit1 = abort). For each pixel in raster order, the block runs three phases: read request to pixel memory, compute handshake with the convolution engine, and write-back request. It exposes busy/done/aborted status and progress for an HPS-readable status PIO.

---
 rtl/filter_job_controller.sv | 139 +++++++++++++
 tb/tb_filter_job_controller.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_job_controller.sv
// Full-frame filter job sequencer: walks every pixel in raster order through
// read -> engine compute -> write-back, with HPS start/abort control and status.
module filter_job_controller #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        activate,
  input  logic [2:0]        opcode,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              eng_start,
  output logic [2:0]        eng_op,
  output logic [DATA_W-1:0] eng_pixel,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] pix_idx,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);

  typedef enum logic [2:0] {
    IDLE, READ, COMPUTE, WAIT_ENG, WRITE, NEXT, FINISH
  } state_t;

  state_t state, state_nxt;
  logic   start_q;
  logic   start_edge;
  logic   abort;
  logic   accept;
  logic   kill;

  assign start_edge = activate[0] & ~start_q;
  assign abort      = activate[1];
  assign accept     = (state == IDLE) && start_edge && !abort;
  // Abort only bites outside IDLE and overrides any ack/eng_done in the same cycle.
  assign kill       = (state != IDLE) && abort;

  assign rd_addr = pix_idx;
  assign wr_addr = pix_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    eng_start = 1'b0;
    case (state)
      IDLE:     if (accept) state_nxt = READ;
      READ: begin
        rd_req = 1'b1;
        if (rd_ack) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        eng_start = 1'b1;
        state_nxt = WAIT_ENG;
      end
      WAIT_ENG: if (eng_done) state_nxt = WRITE;
      WRITE: begin
        wr_req = 1'b1;
        if (wr_ack) state_nxt = NEXT;
      end
      NEXT:     state_nxt = (pix_idx == LAST_PIX) ? FINISH : READ;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q   <= 1'b0;
      eng_op    <= '0;
      eng_pixel <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      pix_idx   <= '0;
      row       <= '0;
      col       <= '0;
    end else begin
      start_q <= activate[0];
      if (kill) begin
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: if (accept) begin
            eng_op  <= opcode;
            pix_idx <= '0;
            row     <= '0;
            col     <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
            busy    <= 1'b1;
          end
          READ:     if (rd_ack) eng_pixel <= rd_data;
          WAIT_ENG: if (eng_done) wr_data <= eng_result;
          // Counters freeze on the last pixel so status shows the final position.
          NEXT: if (pix_idx != LAST_PIX) begin
            pix_idx <= pix_idx + 1'b1;
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
          FINISH: begin
            busy <= 1'b0;
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_filter_job_controller.sv
// Bench for filter_job_controller on a 4x3 frame: randomized memory/engine
// responders, a raster-order reference model, and directed job scenarios.
module tb_filter_job_controller;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk, reset_n;
  logic [1:0]        activate;
  logic [2:0]        opcode;
  logic              rd_req, rd_ack, eng_start, eng_done, wr_req, wr_ack;
  logic [ADDR_W-1:0] rd_addr, wr_addr, pix_idx, row, col;
  logic [DATA_W-1:0] rd_data, eng_pixel, eng_result, wr_data;
  logic [2:0]        eng_op;
  logic              busy, done, aborted;

  filter_job_controller #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .activate(activate), .opcode(opcode),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .eng_start(eng_start), .eng_op(eng_op), .eng_pixel(eng_pixel),
    .eng_done(eng_done), .eng_result(eng_result),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .done(done), .aborted(aborted),
    .pix_idx(pix_idx), .row(row), .col(col)
  );

  int vectors = 0;
  int miscompares = 0;
  int rd_delay = 0, wr_delay = 0, eng_delay = 2;
  logic noise_en = 1'b1;
  logic [DATA_W-1:0] mem [16];
  logic [DATA_W-1:0] writes [$];
  int eng_starts = 0;
  int jobs = 0;
  logic [2:0] exp_op = '0;

  logic [63:0] outs;
  assign outs = {19'd0, rd_req, rd_addr, eng_start, eng_op, eng_pixel, wr_req, wr_addr,
                 wr_data, busy, done, aborted, pix_idx, row, col};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
  endtask

  task automatic start_job(input logic [2:0] op);
    activate = 2'b00;
    step(1);
    opcode = op;
    exp_op = op;
    activate = 2'b01;
    step(1);
    chk("start_busy", busy, 1);
    chk("start_rd_req", rd_req, 1);
    chk("start_done_clr", done, 0);
    chk("start_abort_clr", aborted, 0);
    opcode = 3'($urandom);
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    chk("job_timeout", busy, 0);
  endtask

  task automatic chk_complete();
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_aborted", aborted, 0);
    chk("end_writes", writes.size(), NPIX);
    chk("end_eng_starts", eng_starts, NPIX);
    chk("end_pix_idx", pix_idx, NPIX - 1);
    chk("end_row", row, IMG_H - 1);
    chk("end_col", col, IMG_W - 1);
    chk("end_eng_op", eng_op, exp_op);
  endtask

  // Pixel memory: read port with programmable ack delay, random acks when idle.
  initial begin : rd_resp
    int wc;
    wc = 0;
    rd_ack = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (rd_req) begin
        if (wc >= rd_delay) begin
          rd_ack = 1'b1;
          rd_data = mem[rd_addr];
          wc = 0;
        end else begin
          rd_ack = 1'b0;
          wc++;
        end
      end else begin
        wc = 0;
        rd_ack = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        rd_data = 8'($urandom);
      end
    end
  end

  initial begin : wr_resp
    int wc;
    wc = 0;
    wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_req) begin
        if (wc >= wr_delay) begin
          wr_ack = 1'b1;
          wc = 0;
        end else begin
          wr_ack = 1'b0;
          wc++;
        end
      end else begin
        wc = 0;
        wr_ack = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Engine: result = ~pixel, eng_delay cycles after eng_start (keeps firing after abort).
  initial begin : eng_resp
    eng_done = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (eng_start) begin
        repeat (eng_delay) @(negedge clk);
        eng_done = 1'b1;
        eng_result = ~eng_pixel;
      end
    end
  end

  // Reference model: pixel k of a job is read/written at index k, row k/W, col k%W.
  initial begin : mon
    logic pb, prd, prd_pend, pwr_pend;
    logic [ADDR_W-1:0] prd_addr, pwr_addr;
    logic [DATA_W-1:0] e;
    int p;
    pb = 0; prd = 0; prd_pend = 0; pwr_pend = 0; prd_addr = '0; pwr_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (busy && !pb) begin
        writes.delete();
        eng_starts = 0;
        jobs++;
      end
      if (eng_start) eng_starts++;
      if (rd_req && !prd) begin
        p = writes.size();
        chk("rd_addr", rd_addr, p);
        chk("pix_idx", pix_idx, p);
        chk("row", row, p / IMG_W);
        chk("col", col, p % IMG_W);
        chk("eng_op", eng_op, exp_op);
      end
      if (rd_req && prd_pend) chk("rd_addr_stable", rd_addr, prd_addr);
      if (wr_req && pwr_pend) chk("wr_addr_stable", wr_addr, pwr_addr);
      if (wr_req && wr_ack) begin
        p = writes.size();
        e = ~mem[p];
        chk("wr_addr", wr_addr, p);
        chk("wr_data", wr_data, e);
        chk("eng_start_per_pix", eng_starts, p + 1);
        writes.push_back(wr_data);
      end
      pb = busy;
      prd = rd_req;
      prd_pend = rd_req && !rd_ack;
      pwr_pend = wr_req && !wr_ack;
      prd_addr = rd_addr;
      pwr_addr = wr_addr;
    end
  end

  initial begin : main
    int n, j0, cnt;
    reset_n = 1'b0;
    activate = 2'b00;
    opcode = '0;
    fill_mem();

    // Reset with random control inputs.
    for (int i = 0; i < 4; i++) begin
      activate = 2'($urandom);
      opcode = 3'($urandom);
      step(1);
      chk("reset_outs", outs, 0);
    end
    activate = 2'b00;
    reset_n = 1'b1;
    step(3);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_rd_req", rd_req, 0);

    // Full job, fixed timing.
    rd_delay = 0; wr_delay = 0; eng_delay = 2;
    start_job(3'd5);
    wait_end(400);
    chk_complete();

    // Held start: no new job.
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (rd_req || busy) cnt++;
    end
    chk("held_start_idle", cnt, 0);

    // Re-trigger with random timing and data.
    fill_mem();
    rd_delay = $urandom_range(0, 3); wr_delay = $urandom_range(0, 3); eng_delay = $urandom_range(1, 3);
    start_job(3'($urandom));
    wait_end(1500);
    chk_complete();

    // Abort in WAIT_ENG at pixel 5.
    fill_mem();
    rd_delay = $urandom_range(0, 2); wr_delay = $urandom_range(0, 2); eng_delay = 4;
    start_job(3'($urandom));
    n = 0;
    while (!(eng_start && pix_idx == 5) && n < 500) begin
      step(1);
      n++;
    end
    chk("abort_reach_pix5", {eng_start, pix_idx}, {1'b1, 4'd5});
    step(1);
    activate = 2'b11;
    step(1);
    chk("abort_busy", busy, 0);
    chk("abort_flag", aborted, 1);
    chk("abort_done", done, 0);
    chk("abort_reqs", {rd_req, wr_req, eng_start}, 0);
    chk("abort_pix_idx", pix_idx, 5);
    activate = 2'b10;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (wr_req || busy || !aborted) cnt++;
    end
    chk("abort_quiet", cnt, 0);
    chk("abort_writes", writes.size(), 5);
    // Start rising while abort is high must not launch.
    activate = 2'b00;
    step(1);
    activate = 2'b11;
    step(2);
    chk("start_blocked_by_abort", busy, 0);

    // Restart after abort.
    rd_delay = 0; wr_delay = 0; eng_delay = 1;
    start_job(3'($urandom));
    chk("restart_pix_idx", pix_idx, 0);
    wait_end(1000);
    chk_complete();

    // Backpressure plus start pulses mid-job.
    fill_mem();
    rd_delay = 7; wr_delay = 7; eng_delay = $urandom_range(1, 3);
    j0 = jobs;
    start_job(3'($urandom));
    step(5);
    activate = 2'b00;
    step(3);
    activate = 2'b01;
    step(3);
    activate = 2'b00;
    wait_end(2000);
    chk_complete();
    step(20);
    chk("single_job", jobs, j0 + 1);
    chk("idle_after_bp", busy, 0);

    // Reset mid-job with start held: async clear, then held start counts as an edge.
    fill_mem();
    rd_delay = 1; wr_delay = 1; eng_delay = 1;
    start_job(3'($urandom));
    step(8);
    activate = 2'b01;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", outs, 0);
    step(2);
    chk("held_reset_outs", outs, 0);
    exp_op = opcode;
    reset_n = 1'b1;
    step(1);
    chk("release_start_busy", busy, 1);
    chk("release_start_pix", pix_idx, 0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
